execute_md: RTL and testbench

EXECUTE_MD -- requirements
Module: execute_md

---
 rtl/md_pkg.sv | 52 +++++
 rtl/md_iter.sv | 141 ++++++++++++++
 rtl/execute_md.sv | 150 +++++++++++++++
 tb/tb_execute_md.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and decode helpers for the execute-stage multiply/divide unit.
package md_pkg;

    // Multiply/divide operation select as presented by decode.
    typedef enum logic [3:0] {
        MD_NONE   = 4'd0,
        MD_MUL    = 4'd1,
        MD_MULH   = 4'd2,
        MD_MULHU  = 4'd3,
        MD_MULHSU = 4'd4,
        MD_DIV    = 4'd5,
        MD_DIVU   = 4'd6,
        MD_REM    = 4'd7,
        MD_REMU   = 4'd8
    } md_op_e;

    // Control FSM states of the execute stage.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // True for any encoding that needs the iterative unit; unused encodings
    // fall through to the single-cycle ALU path.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= MD_MUL) && (op <= MD_REMU);
    endfunction

    // True for the four divide/remainder encodings.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op >= MD_DIV) && (op <= MD_REMU);
    endfunction

    // True when the result is the remainder rather than the quotient.
    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // Operand A is interpreted as two's complement.
    function automatic logic op_a_signed(input logic [3:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Operand B is interpreted as two's complement.
    function automatic logic op_b_signed(input logic [3:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_iter.sv
// Radix-2 iterative multiply/divide datapath: works on operand magnitudes,
// one shift-add or restoring-divide step per cycle, signs restored on output.
module md_iter
    import md_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_stall,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);

    // r_hi/r_lo: product high/low halves for multiplies, remainder/quotient
    // for divides. r_opb: multiplicand or divisor magnitude.
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_is_div;
    logic             r_neg_main;
    logic             r_neg_rem;
    logic [3:0]       r_op;

    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_is_div;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic             w_ge;
    logic [XLEN-1:0]  w_step_hi;
    logic [XLEN-1:0]  w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]  w_quot;
    logic [XLEN-1:0]  w_rem;

    // Magnitudes of the operands; the most negative value maps to 2^(XLEN-1),
    // which is exactly representable as an unsigned magnitude.
    assign w_a_neg  = op_a_signed(i_op) && i_a[XLEN-1];
    assign w_b_neg  = op_b_signed(i_op) && i_b[XLEN-1];
    assign w_a_abs  = w_a_neg ? -i_a : i_a;
    assign w_b_abs  = w_b_neg ? -i_b : i_b;
    assign w_is_div = is_div_op(i_op);

    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole 2*XLEN product right by one.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    // Restoring-divide step: bring the next dividend bit into the remainder,
    // trial-subtract the divisor; a clear top bit means the subtract held.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};
    assign w_ge    = ~w_diff[XLEN];

    // Select the next-state values for whichever kind of step is running.
    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_is_div) begin
            w_step_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Operand load on start, one step per unstalled cycle while running,
    // and abort on flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_op       <= '0;
        end else if (i_clear) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (!i_stall) begin
            if (i_start) begin
                r_hi       <= '0;
                r_lo       <= w_is_div ? w_a_abs : w_b_abs;
                r_opb      <= w_is_div ? w_b_abs : w_a_abs;
                r_cnt      <= '0;
                r_run      <= 1'b1;
                r_is_div   <= w_is_div;
                r_neg_main <= w_is_div ? ((w_a_neg ^ w_b_neg) && (i_b != '0))
                                       : (w_a_neg ^ w_b_neg);
                r_neg_rem  <= w_a_neg;
                r_op       <= i_op;
            end else if (r_run) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(XLEN-1)) begin
                    r_run <= 1'b0;
                end
            end
        end
    end

    // The final step is in flight this cycle.
    assign o_done = r_run && (r_cnt == CNT_W'(XLEN-1));

    // Sign correction and result selection from the finished accumulators.
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_main ? -w_prod : w_prod;
    assign w_quot   = r_neg_main ? -r_lo : r_lo;
    assign w_rem    = r_neg_rem ? -r_hi : r_hi;

    // Pick the half or the divide result the operation asked for.
    always_comb begin
        o_result = '0;
        case (r_op)
            MD_MUL:                        o_result = w_prod_s[XLEN-1:0];
            MD_MULH, MD_MULHU, MD_MULHSU:  o_result = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               o_result = w_quot;
            MD_REM, MD_REMU:               o_result = w_rem;
            default:                       o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_md.sv
// Execute stage with an iterative multiply/divide unit: owns the control FSM,
// the divide-by-zero / overflow bypass and the EX/MA pipeline register.
module execute_md
    import md_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int RD_W      = 5,
    parameter int HW_BYPASS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_stall,
    input  logic            i_valid_in,
    input  logic [3:0]      i_md_op,
    input  logic [XLEN-1:0] i_pc,
    input  logic [RD_W-1:0] i_rd,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_data1,
    input  logic [XLEN-1:0] i_data2,
    output logic            o_busy,
    output logic            o_valid_out,
    output logic [XLEN-1:0] o_pc_out,
    output logic [RD_W-1:0] o_rd_out,
    output logic [XLEN-1:0] o_result_out
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       r_state;
    md_state_e       w_next_state;
    logic [XLEN-1:0] r_pc_hold;
    logic [RD_W-1:0] r_rd_hold;
    logic            r_byp;
    logic [XLEN-1:0] r_byp_result;

    logic            w_start;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_bypass;
    logic [XLEN-1:0] w_byp_result;
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_result;

    // A multiply/divide is accepted only from IDLE on a clean, unstalled cycle;
    // ops presented while busy are ignored.
    assign w_start = (r_state == ST_IDLE) && i_valid_in && is_md_op(i_md_op) &&
                     !i_clear && !i_stall;

    // Corner cases whose answers are known without iterating.
    assign w_div_zero = (i_data2 == '0);
    assign w_overflow = op_a_signed(i_md_op) && (i_data1 == MIN_VAL) && (i_data2 == '1);
    assign w_bypass   = (HW_BYPASS != 0) && w_start && is_div_op(i_md_op) &&
                        (w_div_zero || w_overflow);
    assign w_byp_result = is_rem_op(i_md_op) ? (w_div_zero ? i_data1 : '0)
                                             : (w_div_zero ? '1 : MIN_VAL);

    md_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (i_clear),
        .i_stall  (i_stall),
        .i_start  (w_start && !w_bypass),
        .i_op     (i_md_op),
        .i_a      (i_data1),
        .i_b      (i_data2),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: flush wins over stall, stall freezes every state.
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = ST_IDLE;
        end else if (!i_stall) begin
            case (r_state)
                ST_IDLE: if (w_start) w_next_state = w_bypass ? ST_DONE : ST_CALC;
                ST_CALC: if (w_iter_done) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Capture the instruction identity and any bypass answer at acceptance so
    // the result does not depend on upstream keeping its inputs steady.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc_hold    <= '0;
            r_rd_hold    <= '0;
            r_byp        <= 1'b0;
            r_byp_result <= '0;
        end else if (w_start) begin
            r_pc_hold    <= i_pc;
            r_rd_hold    <= i_rd;
            r_byp        <= w_bypass;
            r_byp_result <= w_byp_result;
        end
    end

    // EX/MA register: single-cycle ops pass straight through from IDLE,
    // multiply/divide results are written only from DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_out  <= 1'b0;
            o_pc_out     <= '0;
            o_rd_out     <= '0;
            o_result_out <= '0;
        end else if (i_clear) begin
            o_valid_out <= 1'b0;
        end else if (!i_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid_in && !is_md_op(i_md_op)) begin
                        o_valid_out  <= 1'b1;
                        o_pc_out     <= i_pc;
                        o_rd_out     <= i_rd;
                        o_result_out <= i_alu_result;
                    end else begin
                        o_valid_out <= 1'b0;
                    end
                end
                ST_DONE: begin
                    o_valid_out  <= 1'b1;
                    o_pc_out     <= r_pc_hold;
                    o_rd_out     <= r_rd_hold;
                    o_result_out <= r_byp ? r_byp_result : w_iter_result;
                end
                default: begin
                    o_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_execute_md.sv
// Directed, table-driven bench for execute_md: a 64-bit instance with the
// corner-case bypass and a 32-bit instance without it.
module tb_execute_md;
    import md_pkg::*;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        stall;
    logic        validIn;
    logic        validIn32;
    logic [3:0]  mdOp;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] aluResult;
    logic [63:0] data1;
    logic [63:0] data2;

    logic        busy;
    logic        validOut;
    logic [63:0] pcOut;
    logic [4:0]  rdOut;
    logic [63:0] resultOut;

    logic        busy32;
    logic        validOut32;
    logic [31:0] pcOut32;
    logic [4:0]  rdOut32;
    logic [31:0] resultOut32;

    int checks = 0;
    int errors = 0;

    execute_md #(.XLEN(64), .RD_W(5), .HW_BYPASS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_stall(stall),
        .i_valid_in(validIn), .i_md_op(mdOp), .i_pc(pc), .i_rd(rd),
        .i_alu_result(aluResult), .i_data1(data1), .i_data2(data2),
        .o_busy(busy), .o_valid_out(validOut), .o_pc_out(pcOut),
        .o_rd_out(rdOut), .o_result_out(resultOut)
    );

    execute_md #(.XLEN(32), .RD_W(5), .HW_BYPASS(0)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_stall(stall),
        .i_valid_in(validIn32), .i_md_op(mdOp), .i_pc(pc[31:0]), .i_rd(rd),
        .i_alu_result(aluResult[31:0]), .i_data1(data1[31:0]), .i_data2(data2[31:0]),
        .o_busy(busy32), .o_valid_out(validOut32), .o_pc_out(pcOut32),
        .o_rd_out(rdOut32), .o_result_out(resultOut32)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] alu;
        logic [63:0] expRes;
        int          expLat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Present one instruction, hold it until the result appears (bounded),
    // optionally inserting a 5-cycle stall, then release the inputs.
    task automatic applyStimulus(input logic use32, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] alu, input logic [63:0] pcv,
                                 input logic [4:0] rdv, input int stallAt,
                                 output logic [63:0] res, output logic [63:0] pcRes,
                                 output logic [4:0] rdRes, output int lat,
                                 output logic busyFirst);
        @(posedge clk); #1;
        mdOp = op; data1 = a; data2 = b; aluResult = alu; pc = pcv; rd = rdv;
        if (use32) validIn32 = 1'b1; else validIn = 1'b1;
        lat = 0;
        busyFirst = 1'b0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) busyFirst = use32 ? busy32 : busy;
            if (stallAt > 0 && lat == stallAt) stall = 1'b1;
            if (stallAt > 0 && lat == stallAt + 5) stall = 1'b0;
            if ((use32 ? validOut32 : validOut) === 1'b1) break;
        end
        res   = use32 ? {32'h0, resultOut32} : resultOut;
        pcRes = use32 ? {32'h0, pcOut32} : pcOut;
        rdRes = use32 ? rdOut32 : rdOut;
        validIn = 1'b0; validIn32 = 1'b0; mdOp = MD_NONE; stall = 1'b0;
    endtask

    logic [63:0] res;
    logic [63:0] pcRes;
    logic [4:0]  rdRes;
    int          lat;
    logic        busyFirst;
    int          stray;

    initial begin
        vecs[0]  = '{MD_NONE,   64'h0, 64'h0, 64'h1234, 64'h1234, 1};
        vecs[1]  = '{MD_MUL,    64'd7, -64'd3, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vecs[2]  = '{MD_DIV,    -64'd7, 64'd2, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[3]  = '{MD_REM,    -64'd7, 64'd2, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[4]  = '{MD_DIVU,   64'd5, 64'd0, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[5]  = '{MD_REMU,   64'd5, 64'd0, 64'hDEAD, 64'd5, 2};
        vecs[6]  = '{MD_DIV,    64'h8000_0000_0000_0000, -64'd1, 64'hDEAD, 64'h8000_0000_0000_0000, 2};
        vecs[7]  = '{MD_REM,    64'h8000_0000_0000_0000, -64'd1, 64'hDEAD, 64'h0, 2};
        vecs[8]  = '{MD_MULH,   64'h8000_0000_0000_0000, 64'd2, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[9]  = '{MD_MULHSU, -64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[10] = '{MD_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[11] = '{MD_DIVU,   64'd100, 64'd7, 64'hDEAD, 64'd14, 66};
        vecs[12] = '{MD_REMU,   64'd100, 64'd7, 64'hDEAD, 64'd2, 66};
        vecs[13] = '{MD_DIV,    64'd7, -64'd2, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[14] = '{MD_REM,    64'd7, -64'd2, 64'hDEAD, 64'd1, 66};
        vecs[15] = '{MD_REM,    -64'd7, 64'd0, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF9, 2};

        rst = 1'b1; clear = 1'b0; stall = 1'b0; validIn = 1'b0; validIn32 = 1'b0;
        mdOp = MD_NONE; pc = '0; rd = '0; aluResult = '0; data1 = '0; data2 = '0;
        #2;
        checkOutput("reset valid_out", {63'h0, validOut}, 64'h0);
        checkOutput("reset busy", {63'h0, busy}, 64'h0);
        checkOutput("reset result_out", resultOut, 64'h0);
        checkOutput("reset pc_out", pcOut, 64'h0);
        checkOutput("reset rd_out", {59'h0, rdOut}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].alu,
                          64'h1000 + 64'(i * 4), 5'(i + 1), 0, res, pcRes, rdRes, lat, busyFirst);
            checkOutput($sformatf("vec%0d result", i), res, vecs[i].expRes);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d busy", i), {63'h0, busyFirst},
                        {63'h0, (vecs[i].op != MD_NONE)});
            checkOutput($sformatf("vec%0d pc_out", i), pcRes, 64'h1000 + 64'(i * 4));
            checkOutput($sformatf("vec%0d rd_out", i), {59'h0, rdRes}, {59'h0, 5'(i + 1)});
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d valid drop", i), {63'h0, validOut}, 64'h0);
        end

        // Stall for five cycles in the middle of a multiply.
        applyStimulus(1'b0, MD_MUL, 64'd7, -64'd3, 64'hDEAD, 64'h2000, 5'd9, 10,
                      res, pcRes, rdRes, lat, busyFirst);
        checkOutput("stall result", res, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("stall latency", 64'(lat), 64'd71);

        // Flush a divide in its tenth cycle; its result must never appear.
        @(posedge clk); #1;
        mdOp = MD_DIV; data1 = -64'd7; data2 = 64'd2; validIn = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("pre-clear busy", {63'h0, busy}, 64'h1);
        clear = 1'b1; validIn = 1'b0; mdOp = MD_NONE;
        @(posedge clk); #1;
        clear = 1'b0;
        checkOutput("clear busy", {63'h0, busy}, 64'h0);
        checkOutput("clear valid_out", {63'h0, validOut}, 64'h0);
        stray = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (validOut) stray++;
        end
        checkOutput("cleared op output", 64'(stray), 64'h0);
        applyStimulus(1'b0, MD_NONE, 64'h0, 64'h0, 64'h55, 64'h3000, 5'd3, 0,
                      res, pcRes, rdRes, lat, busyFirst);
        checkOutput("post-clear result", res, 64'h55);
        checkOutput("post-clear latency", 64'(lat), 64'd1);

        // Reset in the middle of a multiply discards it.
        @(posedge clk); #1;
        mdOp = MD_MUL; data1 = 64'd3; data2 = 64'd4; validIn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("calc reset busy", {63'h0, busy}, 64'h0);
        checkOutput("calc reset valid_out", {63'h0, validOut}, 64'h0);
        checkOutput("calc reset result_out", resultOut, 64'h0);
        validIn = 1'b0; mdOp = MD_NONE;
        #2;
        rst = 1'b0;
        stray = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (validOut) stray++;
        end
        checkOutput("reset op output", 64'(stray), 64'h0);

        // 32-bit instance, iterating even on divide by zero.
        applyStimulus(1'b1, MD_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0, 64'h40, 5'd4, 0,
                      res, pcRes, rdRes, lat, busyFirst);
        checkOutput("x32 mulhu result", res, 64'hFFFF_FFFE);
        checkOutput("x32 mulhu latency", 64'(lat), 64'd34);
        applyStimulus(1'b1, MD_DIVU, 64'd5, 64'd0, 64'h0, 64'h44, 5'd5, 0,
                      res, pcRes, rdRes, lat, busyFirst);
        checkOutput("x32 divu0 result", res, 64'hFFFF_FFFF);
        checkOutput("x32 divu0 latency", 64'(lat), 64'd34);
        applyStimulus(1'b1, MD_REMU, 64'd5, 64'd0, 64'h0, 64'h48, 5'd6, 0,
                      res, pcRes, rdRes, lat, busyFirst);
        checkOutput("x32 remu0 result", res, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
